// File: rtl/tower_stage_sequencer.sv
// Game-flow controller: runs three place-then-wave stages, one tower placer enabled at a time,
// with a per-placement timeout and a win/lose outcome held until the next start.
module tower_stage_sequencer #(
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int CNT_W          = 29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       wave_done,
    input  logic       game_over,
    input  logic       stage_1_tower_done,
    input  logic       stage_2_tower_done,
    input  logic       stage_3_tower_done,
    output logic       stage_1_draw_tower,
    output logic       stage_2_draw_tower,
    output logic       stage_3_draw_tower,
    output logic       wave_start,
    output logic       placement_timeout,
    output logic [1:0] stage_num,
    output logic [1:0] towers_placed,
    output logic       seq_win,
    output logic       seq_lose,
    output logic [3:0] o_dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PLACE1 = 4'd1,
        S_WAVE1  = 4'd2,
        S_PLACE2 = 4'd3,
        S_WAVE2  = 4'd4,
        S_PLACE3 = 4'd5,
        S_WAVE3  = 4'd6,
        S_WIN    = 4'd7,
        S_LOSE   = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_draw;
    logic [1:0]       r_stage_num;
    logic [1:0]       r_towers;
    logic             r_wave_start;
    logic             r_timeout;
    logic             r_win;
    logic             r_lose;

    state_t           w_next_phase;
    logic             w_done_active;
    logic [2:0]       w_draw_next;

    // Successor of the current place/wave state and the done line of the active stage only.
    always_comb begin
        w_next_phase  = S_IDLE;
        w_done_active = 1'b0;
        case (r_state)
            S_PLACE1: begin w_next_phase = S_WAVE1;  w_done_active = stage_1_tower_done; end
            S_PLACE2: begin w_next_phase = S_WAVE2;  w_done_active = stage_2_tower_done; end
            S_PLACE3: begin w_next_phase = S_WAVE3;  w_done_active = stage_3_tower_done; end
            S_WAVE1:  w_next_phase = S_PLACE2;
            S_WAVE2:  w_next_phase = S_PLACE3;
            default:  w_next_phase = S_IDLE;
        endcase
    end

    // Enable for the following stage: stage n in a wave hands over to bit n (stage n+1).
    assign w_draw_next = 3'b001 << r_stage_num;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_draw       <= '0;
            r_stage_num  <= '0;
            r_towers     <= '0;
            r_wave_start <= 1'b0;
            r_timeout    <= 1'b0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
        end else begin
            r_wave_start <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        r_state     <= S_PLACE1;
                        r_timer     <= '0;
                        r_towers    <= '0;
                        r_draw      <= 3'b001;
                        r_stage_num <= 2'd1;
                        r_win       <= 1'b0;
                        r_lose      <= 1'b0;
                    end
                end
                S_PLACE1, S_PLACE2, S_PLACE3: begin
                    if (game_over) begin
                        r_state     <= S_LOSE;
                        r_lose      <= 1'b1;
                        r_draw      <= '0;
                        r_stage_num <= '0;
                        r_timer     <= '0;
                    end else if (w_done_active || (r_timer == TIMER_LAST)) begin
                        r_state      <= w_next_phase;
                        r_draw       <= '0;
                        r_wave_start <= 1'b1;
                        r_timer      <= '0;
                        // A real placement beats a coincident timer expiry.
                        if (w_done_active) begin
                            if (r_towers != 2'd3) r_towers <= r_towers + 2'd1;
                        end else begin
                            r_timeout <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAVE1, S_WAVE2, S_WAVE3: begin
                    if (game_over) begin
                        r_state     <= S_LOSE;
                        r_lose      <= 1'b1;
                        r_stage_num <= '0;
                    end else if (wave_done && !r_wave_start) begin
                        // r_wave_start marks the entry cycle, where wave_done is not trusted yet.
                        if (r_state == S_WAVE3) begin
                            r_state     <= S_WIN;
                            r_win       <= 1'b1;
                            r_stage_num <= '0;
                        end else begin
                            r_state     <= w_next_phase;
                            r_draw      <= w_draw_next;
                            r_stage_num <= r_stage_num + 2'd1;
                            r_timer     <= '0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_draw      <= '0;
                    r_stage_num <= '0;
                end
            endcase
        end
    end

    assign stage_1_draw_tower = r_draw[0];
    assign stage_2_draw_tower = r_draw[1];
    assign stage_3_draw_tower = r_draw[2];
    assign wave_start         = r_wave_start;
    assign placement_timeout  = r_timeout;
    assign stage_num          = r_stage_num;
    assign towers_placed      = r_towers;
    assign seq_win            = r_win;
    assign seq_lose           = r_lose;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_tower_stage_sequencer.sv
// Bench for tower_stage_sequencer: directed game scenarios plus random play, every cycle's
// outputs predicted by a stage/phase model and compared through an expected-value queue.
module tb_tower_stage_sequencer;

    localparam int TIMEOUT = 16;
    localparam int W       = 11;

    localparam int M_IDLE  = 0;
    localparam int M_PLACE = 1;
    localparam int M_WAVE  = 2;
    localparam int M_WIN   = 3;
    localparam int M_LOSE  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, wave_done, game_over;
    logic       d1, d2, d3;
    logic       draw1, draw2, draw3;
    logic       wave_start, placement_timeout;
    logic [1:0] stage_num, towers_placed;
    logic       seq_win, seq_lose;
    logic [3:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int ws_cnt   = 0;

    logic [W-1:0] exp_q[$];

    // Reference model: game phase, stage 1..3, cycles spent placing, towers placed, pulses.
    int m_mode, m_stage, m_cyc, m_towers;
    bit m_ws, m_to;

    always #5 clk = ~clk;

    tower_stage_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .wave_done(wave_done), .game_over(game_over),
        .stage_1_tower_done(d1), .stage_2_tower_done(d2), .stage_3_tower_done(d3),
        .stage_1_draw_tower(draw1), .stage_2_draw_tower(draw2), .stage_3_draw_tower(draw3),
        .wave_start(wave_start), .placement_timeout(placement_timeout),
        .stage_num(stage_num), .towers_placed(towers_placed),
        .seq_win(seq_win), .seq_lose(seq_lose), .o_dbg_state(dbg_state)
    );

    function automatic logic [W-1:0] dut_vec();
        return {draw1, draw2, draw3, wave_start, placement_timeout, stage_num, towers_placed,
                seq_win, seq_lose};
    endfunction

    function automatic logic [W-1:0] model_vec();
        logic       active;
        logic [1:0] sn;
        active = (m_mode == M_PLACE) || (m_mode == M_WAVE);
        sn     = active ? 2'(m_stage) : 2'd0;
        return {(m_mode == M_PLACE && m_stage == 1), (m_mode == M_PLACE && m_stage == 2),
                (m_mode == M_PLACE && m_stage == 3), m_ws, m_to, sn, 2'(m_towers),
                (m_mode == M_WIN), (m_mode == M_LOSE)};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_stage = 0; m_cyc = 0; m_towers = 0; m_ws = 0; m_to = 0;
    endtask

    task automatic model_step(input bit s, input bit wd, input bit go,
                              input bit x1, input bit x2, input bit x3);
        bit first_wave_cycle;
        bit done_here;
        first_wave_cycle = m_ws;
        m_ws = 0;
        m_to = 0;
        done_here = (m_stage == 1) ? x1 : (m_stage == 2) ? x2 : x3;
        case (m_mode)
            M_IDLE, M_WIN, M_LOSE: begin
                if (s) begin m_mode = M_PLACE; m_stage = 1; m_cyc = 0; m_towers = 0; end
            end
            M_PLACE: begin
                if (go) m_mode = M_LOSE;
                else if (done_here) begin
                    m_mode = M_WAVE; m_ws = 1;
                    m_towers = (m_towers < 3) ? m_towers + 1 : 3;
                end else if (m_cyc == TIMEOUT - 1) begin
                    m_mode = M_WAVE; m_ws = 1; m_to = 1;
                end else m_cyc++;
            end
            M_WAVE: begin
                if (go) m_mode = M_LOSE;
                else if (wd && !first_wave_cycle) begin
                    if (m_stage == 3) m_mode = M_WIN;
                    else begin m_stage++; m_mode = M_PLACE; m_cyc = 0; end
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // Driver: called just after a rising edge; drives, predicts, and returns on the next edge.
    task automatic step(input bit s, input bit wd, input bit go,
                        input bit x1, input bit x2, input bit x3);
        #2;
        start = s; wave_done = wd; game_over = go; d1 = x1; d2 = x2; d3 = x3;
        model_step(s, wd, go, x1, x2, x3);
        exp_q.push_back(model_vec());
        @(posedge clk);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b1;
        start = 0; wave_done = 0; game_over = 0; d1 = 0; d2 = 0; d3 = 0;
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", dut_vec(), {W{1'b0}});
        end
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Monitor: outputs settle just after each edge; compare against the oldest prediction.
    initial begin
        logic [W-1:0] exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (dut_vec() !== exp_v) begin
                    failures++;
                    $display("FAIL outputs t=%0t got=%b exp=%b (draw123,ws,to,stage,towers,win,lose)",
                             $time, dut_vec(), exp_v);
                end
                checks++;
                if ($countones({draw1, draw2, draw3}) > 1) begin
                    failures++;
                    $display("FAIL draw_onehot got=%b exp=at most one bit", {draw1, draw2, draw3});
                end
                if (wave_start === 1'b1) ws_cnt++;
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 0; wave_done = 0; game_over = 0; d1 = 0; d2 = 0; d3 = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", int'(dut_vec()), 0);
        #1 reset = 1'b0;
        @(posedge clk);

        // Idle ignores everything but start.
        for (int i = 0; i < 6; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Happy path through all three stages; wave_done on the wave entry cycle is ignored.
        ws_cnt = 0;
        step(1, 0, 0, 0, 0, 0);
        idle_n(5); step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0); idle_n(2); step(0, 1, 0, 0, 0, 0);
        idle_n(5); step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0); idle_n(1); step(0, 1, 0, 0, 0, 0);
        idle_n(5); step(0, 0, 0, 0, 0, 1);
        idle_n(3); step(0, 1, 0, 0, 0, 0);
        idle_n(2);
        #2;
        check_val("happy_wave_starts", ws_cnt, 3);
        check_val("happy_towers", int'(towers_placed), 3);
        check_val("happy_win", int'(seq_win), 1);
        @(posedge clk);

        // Timeout in stage 1, then done2 on the last timer cycle, then game_over with done3.
        step(1, 0, 0, 0, 0, 0);
        idle_n(TIMEOUT);
        idle_n(2); step(0, 1, 0, 0, 0, 0);
        idle_n(TIMEOUT - 1); step(0, 0, 0, 0, 1, 0);
        idle_n(1); step(0, 1, 0, 0, 0, 0);
        idle_n(3); step(0, 0, 1, 0, 0, 1);
        idle_n(2);

        // Restart, then in stage 2 the foreign done lines must be ignored; reset mid-wave 2.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle_n(1); step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        idle_n(3);
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 1, 1);

        // Lose with one tower placed, then restart clears count and lose flag.
        step(1, 0, 0, 0, 0, 0);
        idle_n(2); step(0, 0, 0, 1, 0, 0);
        idle_n(1); step(0, 1, 0, 0, 0, 0);
        idle_n(2); step(0, 0, 1, 0, 0, 0);
        idle_n(2); step(1, 0, 0, 0, 0, 0);
        idle_n(2);

        // Random play with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            else step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 11) == 0),
                      1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 11) == 0));
        end

        #3;
        check_val("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
